// File: rtl/vproc_vreg_rd_arb.sv
`default_nettype none
// vproc_vreg_rd_arb: arbitrates pipeline vreg read requests onto register file read ports.
// Round-robin per port by default; define VPROC_VREG_RD_FIXED_PRIO_EN for fixed lowest-index priority.
module vproc_vreg_rd_arb #(
  parameter int unsigned VREG_W                  = 128,
  parameter int unsigned VPORT_RD_CNT            = 2,
  parameter int unsigned PIPE_CNT                = 2,
  parameter int unsigned PIPE_VPORT_RD[PIPE_CNT] = '{0, 1},
  parameter bit          DONT_CARE_ZERO          = 1'b0
) (
  input  logic                                 clk_i,
  input  logic                                 sync_rst_i,
  input  logic [PIPE_CNT-1:0]                  vreg_rd_valid_i,
  input  logic [PIPE_CNT-1:0][4:0]             vreg_rd_addr_i,
  output logic [PIPE_CNT-1:0]                  vreg_rd_ready_o,
  input  logic [31:0]                          pend_vreg_wr_i,
  output logic [PIPE_CNT-1:0]                  vreg_rd_rvalid_o,
  output logic [PIPE_CNT-1:0][VREG_W-1:0]      vreg_rd_rdata_o,
  output logic [VPORT_RD_CNT-1:0]              vregfile_rd_en_o,
  output logic [VPORT_RD_CNT-1:0][4:0]         vregfile_rd_addr_o,
  input  logic [VPORT_RD_CNT-1:0][VREG_W-1:0]  vregfile_rd_data_i
);

  localparam int unsigned       PTR_W   = (PIPE_CNT > 1) ? $clog2(PIPE_CNT) : 1;
  localparam logic [4:0]        ADDR_DC = DONT_CARE_ZERO ? '0 : 'x;
  localparam logic [VREG_W-1:0] DATA_DC = DONT_CARE_ZERO ? '0 : 'x;

  logic [PIPE_CNT-1:0]                elig;
  logic [PIPE_CNT-1:0]                grant;
  logic [PIPE_CNT-1:0]                rvalid_q;
  logic [VPORT_RD_CNT-1:0][PTR_W-1:0] start;

  // A pending write to the addressed vreg hides the request entirely.
  always_comb begin
    elig = '0;
    for (int j = 0; j < PIPE_CNT; j++) begin
      elig[j] = vreg_rd_valid_i[j] & ~pend_vreg_wr_i[vreg_rd_addr_i[j]] & ~sync_rst_i;
    end
  end

`ifdef VPROC_VREG_RD_FIXED_PRIO_EN
  assign start = '0;
`else
  logic [VPORT_RD_CNT-1:0][PTR_W-1:0] ptr;
  logic [VPORT_RD_CNT-1:0][PTR_W-1:0] ptr_nxt;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      ptr <= '0;
    end else begin
      for (int p = 0; p < VPORT_RD_CNT; p++) begin
        if (vregfile_rd_en_o[p]) begin
          ptr[p] <= ptr_nxt[p];
        end
      end
    end
  end

  assign start = ptr;
`endif

  always_comb begin
    logic found;
    found              = 1'b0;
    grant              = '0;
    vregfile_rd_en_o   = '0;
    vregfile_rd_addr_o = {VPORT_RD_CNT{ADDR_DC}};
`ifndef VPROC_VREG_RD_FIXED_PRIO_EN
    ptr_nxt            = ptr;
`endif
    for (int unsigned p = 0; p < VPORT_RD_CNT; p++) begin
      found = 1'b0;
      // Pass 0 scans indices at or above the pointer, pass 1 wraps around from index 0.
      for (int pass = 0; pass < 2; pass++) begin
        for (int j = 0; j < PIPE_CNT; j++) begin
          if (!found && elig[j] && (PIPE_VPORT_RD[j] == p) &&
              ((pass == 1) || (PTR_W'(j) >= start[p]))) begin
            found                 = 1'b1;
            grant[j]              = 1'b1;
            vregfile_rd_en_o[p]   = 1'b1;
            vregfile_rd_addr_o[p] = vreg_rd_addr_i[j];
`ifndef VPROC_VREG_RD_FIXED_PRIO_EN
            ptr_nxt[p]            = (j == PIPE_CNT - 1) ? '0 : PTR_W'(j + 1);
`endif
          end
        end
      end
    end
  end

  assign vreg_rd_ready_o = grant;

  always_ff @(posedge clk_i) begin
    if (sync_rst_i) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= grant;
    end
  end

  assign vreg_rd_rvalid_o = rvalid_q;

  // Each pipe is hard-wired to its port, so the response only needs the registered valid.
  generate
    for (genvar j = 0; j < PIPE_CNT; j++) begin : g_resp
      assign vreg_rd_rdata_o[j] = rvalid_q[j] ? vregfile_rd_data_i[PIPE_VPORT_RD[j]] : DATA_DC;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_vproc_vreg_rd_arb.sv
`default_nettype none
// Directed bench for vproc_vreg_rd_arb: dut_a gives each pipe its own port, dut_b shares port 0.
module tb_vproc_vreg_rd_arb;
  localparam int W = 128;
  localparam logic [W-1:0] D0 = {16{8'hA5}};
  localparam logic [W-1:0] D1 = {16{8'h5A}};
  localparam logic [W-1:0] D2 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          valid;
  logic [1:0][4:0]     addr;
  logic [31:0]         pend;
  logic [1:0][W-1:0]   rf_data;

  logic [1:0]          rdy_a, rv_a, en_a, rdy_b, rv_b, en_b;
  logic [1:0][W-1:0]   rd_a, rd_b;
  logic [1:0][4:0]     pa_a, pa_b;

  vproc_vreg_rd_arb #(.VREG_W(W), .VPORT_RD_CNT(2), .PIPE_CNT(2), .PIPE_VPORT_RD('{0, 1}),
                      .DONT_CARE_ZERO(1'b1)) dut_a (
    .clk_i(clk), .sync_rst_i(rst), .vreg_rd_valid_i(valid), .vreg_rd_addr_i(addr),
    .vreg_rd_ready_o(rdy_a), .pend_vreg_wr_i(pend), .vreg_rd_rvalid_o(rv_a),
    .vreg_rd_rdata_o(rd_a), .vregfile_rd_en_o(en_a), .vregfile_rd_addr_o(pa_a),
    .vregfile_rd_data_i(rf_data));

  vproc_vreg_rd_arb #(.VREG_W(W), .VPORT_RD_CNT(2), .PIPE_CNT(2), .PIPE_VPORT_RD('{0, 0}),
                      .DONT_CARE_ZERO(1'b1)) dut_b (
    .clk_i(clk), .sync_rst_i(rst), .vreg_rd_valid_i(valid), .vreg_rd_addr_i(addr),
    .vreg_rd_ready_o(rdy_b), .pend_vreg_wr_i(pend), .vreg_rd_rvalid_o(rv_b),
    .vreg_rd_rdata_o(rd_b), .vregfile_rd_en_o(en_b), .vregfile_rd_addr_o(pa_b),
    .vregfile_rd_data_i(rf_data));

  typedef struct {
    logic [1:0] valid; logic [4:0] a0, a1; logic [31:0] pend; logic [W-1:0] d0, d1;
    logic [1:0] ardy, aen; logic [4:0] apa0, apa1; logic [1:0] arv; logic [W-1:0] ard0, ard1;
    logic [1:0] brdy; logic ben; logic [4:0] bpa; logic [1:0] brv; logic [W-1:0] brd0, brd1;
  } vec_t;

  localparam int NV = 13;
  vec_t tbl[NV];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string t, input logic [1:0] rdy, input logic [1:0] en,
                       input logic [4:0] pa0, input logic [4:0] pa1, input logic [1:0] rv,
                       input logic [W-1:0] rd0, input logic [W-1:0] rd1);
    chk({t, " a.ready"},  W'(rdy_a),    W'(rdy));
    chk({t, " a.en"},     W'(en_a),     W'(en));
    chk({t, " a.addr0"},  W'(pa_a[0]),  W'(pa0));
    chk({t, " a.addr1"},  W'(pa_a[1]),  W'(pa1));
    chk({t, " a.rvalid"}, W'(rv_a),     W'(rv));
    chk({t, " a.rdata0"}, rd_a[0], rd0);
    chk({t, " a.rdata1"}, rd_a[1], rd1);
  endtask

  task automatic chk_b(input string t, input logic [1:0] rdy, input logic en, input logic [4:0] pa,
                       input logic [1:0] rv, input logic [W-1:0] rd0, input logic [W-1:0] rd1);
    chk({t, " b.ready"},  W'(rdy_b),    W'(rdy));
    chk({t, " b.en"},     W'(en_b),     W'({1'b0, en}));
    chk({t, " b.addr0"},  W'(pa_b[0]),  W'(pa));
    chk({t, " b.rvalid"}, W'(rv_b),     W'(rv));
    chk({t, " b.rdata0"}, rd_b[0], rd0);
    chk({t, " b.rdata1"}, rd_b[1], rd1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{2'b01, 5'd5, 5'd0, 32'h0, D0, D1, 2'b01, 2'b01, 5'd5, 5'd0, 2'b00, '0, '0, 2'b01, 1'b1, 5'd5, 2'b00, '0, '0};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 32'h0, D0, D1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b01, D0, '0, 2'b00, 1'b0, 5'd0, 2'b01, D0, '0};
`ifdef VPROC_VREG_RD_FIXED_PRIO_EN
    tbl[2]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b00, '0, '0, 2'b01, 1'b1, 5'd1, 2'b00, '0, '0};
    tbl[3]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b01, 1'b1, 5'd1, 2'b01, D0, '0};
    tbl[4]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b01, 1'b1, 5'd1, 2'b01, D0, '0};
    tbl[5]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b01, 1'b1, 5'd1, 2'b01, D0, '0};
`else
    tbl[2]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b00, '0, '0, 2'b10, 1'b1, 5'd2, 2'b00, '0, '0};
    tbl[3]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b01, 1'b1, 5'd1, 2'b10, '0, D0};
    tbl[4]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b10, 1'b1, 5'd2, 2'b01, D0, '0};
    tbl[5]  = '{2'b11, 5'd1, 5'd2, 32'h0, D0, D1, 2'b11, 2'b11, 5'd1, 5'd2, 2'b11, D0, D1, 2'b01, 1'b1, 5'd1, 2'b10, '0, D0};
`endif
    tbl[6]  = '{2'b10, 5'd1, 5'd2, 32'h0, D0, D1, 2'b10, 2'b10, 5'd0, 5'd2, 2'b11, D0, D1, 2'b10, 1'b1, 5'd2, 2'b01, D0, '0};
    tbl[7]  = '{2'b11, 5'd3, 5'd4, 32'h8, D0, D1, 2'b10, 2'b10, 5'd0, 5'd4, 2'b10, '0, D1, 2'b10, 1'b1, 5'd4, 2'b10, '0, D0};
    tbl[8]  = '{2'b11, 5'd3, 5'd4, 32'h0, D0, D1, 2'b11, 2'b11, 5'd3, 5'd4, 2'b10, '0, D1, 2'b01, 1'b1, 5'd3, 2'b10, '0, D0};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 32'h0, D0, D1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, D0, D1, 2'b00, 1'b0, 5'd0, 2'b01, D0, '0};
    tbl[10] = '{2'b00, 5'd0, 5'd0, 32'h0, D0, D1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, '0, '0, 2'b00, 1'b0, 5'd0, 2'b00, '0, '0};
    tbl[11] = '{2'b01, 5'd3, 5'd0, 32'hFFFF_FFF7, D0, D1, 2'b01, 2'b01, 5'd3, 5'd0, 2'b00, '0, '0, 2'b01, 1'b1, 5'd3, 2'b00, '0, '0};
    tbl[12] = '{2'b00, 5'd0, 5'd0, 32'h0, D2, D1, 2'b00, 2'b00, 5'd0, 5'd0, 2'b01, D2, '0, 2'b00, 1'b0, 5'd0, 2'b01, D2, '0};

    // Reset with requests present: nothing may be granted.
    rst = 1'b1; valid = 2'b11; addr = {5'd2, 5'd1}; pend = '0; rf_data = {D1, D0};
    @(negedge clk);
    chk_a("reset", 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, '0, '0);
    chk_b("reset", 2'b00, 1'b0, 5'd0, 2'b00, '0, '0);
    tick();
    rst = 1'b0; valid = '0; addr = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_a($sformatf("idle%0d", c), 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, '0, '0);
      chk_b($sformatf("idle%0d", c), 2'b00, 1'b0, 5'd0, 2'b00, '0, '0);
      tick();
    end

    for (int i = 0; i < NV; i++) begin
      valid = tbl[i].valid; addr = {tbl[i].a1, tbl[i].a0};
      pend = tbl[i].pend; rf_data = {tbl[i].d1, tbl[i].d0};
      @(negedge clk);
      chk_a($sformatf("vec%0d", i), tbl[i].ardy, tbl[i].aen, tbl[i].apa0, tbl[i].apa1,
            tbl[i].arv, tbl[i].ard0, tbl[i].ard1);
      chk_b($sformatf("vec%0d", i), tbl[i].brdy, tbl[i].ben, tbl[i].bpa,
            tbl[i].brv, tbl[i].brd0, tbl[i].brd1);
      tick();
    end

    // Pipe1 reads v3 while a write to v3 is pending for three cycles.
    valid = 2'b10; addr = {5'd3, 5'd0}; pend = 32'h8; rf_data = {D1, D0};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_a($sformatf("pend%0d", c), 2'b00, 2'b00, 5'd0, 5'd0, 2'b00, '0, '0);
      tick();
    end
    pend = '0;
    @(negedge clk);
    chk_a("pend_clear", 2'b10, 2'b10, 5'd0, 5'd3, 2'b00, '0, '0);
    tick();
    valid = '0; addr = '0;
    @(negedge clk);
    chk_a("pend_resp", 2'b00, 2'b00, 5'd0, 5'd0, 2'b10, '0, D1);
    tick();

    // Grant, then reset on the following edge: rvalid and pointers must clear.
    rst = 1'b1;
    tick();
    rst = 1'b0; valid = 2'b11; addr = {5'd2, 5'd1};
    @(negedge clk);
    chk_b("rg_grant", 2'b01, 1'b1, 5'd1, 2'b00, '0, '0);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk_a("rg_inrst", 2'b00, 2'b00, 5'd0, 5'd0, 2'b11, D0, D1);
    chk_b("rg_inrst", 2'b00, 1'b0, 5'd0, 2'b01, D0, '0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_a("rg_after", 2'b11, 2'b11, 5'd1, 5'd2, 2'b00, '0, '0);
    chk_b("rg_after", 2'b01, 1'b1, 5'd1, 2'b00, '0, '0);
    tick();
    valid = '0; addr = '0;
    @(negedge clk);
    chk_b("rg_resp", 2'b00, 1'b0, 5'd0, 2'b01, D0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vproc_vreg_rd_arb.md
Name: vproc_vreg_rd_arb

Overview:
Read-side counterpart of the vector register write multiplexer. It arbitrates read requests from PIPE_CNT execution pipelines onto VPORT_RD_CNT vector register file read ports. Each pipeline is statically mapped to one port. The block blocks reads of registers with pending writes and returns read data one cycle after the grant.

Parameters:
VREG_W, 128, vector register width in bits
VPORT_RD_CNT, 2, number of register file read ports
PIPE_CNT, 2, number of requesting pipelines
PIPE_VPORT_RD[PIPE_CNT], '{0,1}, read port index used by each pipeline; every entry < VPORT_RD_CNT
DONT_CARE_ZERO, 1'b0, drive don't-care outputs to '0 instead of 'x

Ports:
clk_i  in  1  clock, all logic on rising edge
sync_rst_i  in  1  synchronous reset, active-high
vreg_rd_valid_i  in  PIPE_CNT  per-pipe read request
vreg_rd_addr_i  in  PIPE_CNT x 5  per-pipe vreg address
vreg_rd_ready_o  out  PIPE_CNT  per-pipe grant; request accepted when valid & ready
pend_vreg_wr_i  in  32  one bit per vreg with an outstanding write
vreg_rd_rvalid_o  out  PIPE_CNT  read data valid, one cycle after grant
vreg_rd_rdata_o  out  PIPE_CNT x VREG_W  read data
vregfile_rd_en_o  out  VPORT_RD_CNT  port read enable
vregfile_rd_addr_o  out  VPORT_RD_CNT x 5  port read address
vregfile_rd_data_i  in  VPORT_RD_CNT x VREG_W  port data, valid one cycle after enable (synchronous RAM)

Behaviour:
- Reset: sync_rst_i high at a clock edge clears all round-robin pointers to 0 and all vreg_rd_rvalid_o to 0 at that edge.
  - During reset, vreg_rd_ready_o and vregfile_rd_en_o are forced 0.
  - A grant in the cycle reset is asserted produces no rvalid.
- Eligibility: pipe j is eligible when vreg_rd_valid_i[j] & ~pend_vreg_wr_i[vreg_rd_addr_i[j]].
  - A pending write blocks the read: ready stays 0 and no port slot is consumed.
- Arbitration is per port p, among eligible pipes with PIPE_VPORT_RD[j]==p:
  - Winner is the first eligible index ≥ ptr[p], wrapping modulo PIPE_CNT.
  - Winner gets vreg_rd_ready_o=1, vregfile_rd_en_o[p]=1, vregfile_rd_addr_o[p]=its address.
  - All other pipes on that port get ready 0.
- Pointer update: on a grant, ptr[p] <= (winner+1) mod PIPE_CNT. With no grant, ptr[p] holds.
- Ready is combinational from valid, addr and pend_vreg_wr_i; there is no registered state in the request path. Pipes hold valid/addr stable until granted. Dropping valid before grant is legal and has no effect.
- Response: a grant at cycle N sets vreg_rd_rvalid_o[j]=1 for exactly cycle N+1. That cycle, vreg_rd_rdata_o[j]=vregfile_rd_data_i[PIPE_VPORT_RD[j]].
  - A registered per-pipe valid bit drives rvalid; the port is fixed per pipe.
  - With rvalid 0, rdata is '0/'x per DONT_CARE_ZERO.
- Back-to-back: one grant per port per cycle, full throughput. The response at N+1 and a new grant at N+1 coexist.
- Idle port: en 0, addr '0/'x per DONT_CARE_ZERO.
- Simultaneous events:
  - A pend bit rising in the same cycle as a request blocks it (combinational check).
  - A pend bit clearing makes the pipe eligible that same cycle.
- Pipes sharing a port with no contention are granted the same cycle they request (zero-wait).

Optional Feature:
Macro VPROC_VREG_RD_FIXED_PRIO_EN.
- Defined: per-port fixed priority, lowest eligible pipe index wins. No pointer registers are instantiated.
- Undefined: round-robin as specified above.
- Response timing and hazard blocking are identical in both cases.

Test Plan:
- Reset then idle, no requests: all outputs 0 (DONT_CARE_ZERO=1). rvalid stays 0 for 10 cycles.
- Pipe0 reads v5 on port 0, uncontended: ready0=1 and en[0]=1, addr=5 in cycle N. Data 0xA5..A5 returned → rvalid0=1, rdata0=0xA5..A5 in N+1 only.
- PIPE_VPORT_RD='{0,0}, both pipes request continuously: grants alternate 0,1,0,1 over 4 cycles, one rvalid per cycle. With VPROC_VREG_RD_FIXED_PRIO_EN, pipe0 is granted all 4 cycles.
- Pipe1 requests v3 while pend_vreg_wr_i[3]=1 for 3 cycles, then 0: ready1=0 and en=0 for 3 cycles, grant in cycle 4, rvalid1 in cycle 5.
- Shared port, pipe0 blocked by pend bit, pipe1 eligible: pipe1 granted. Pointer advances to 0, so pipe0 wins next once unblocked.
- Grant at cycle N with sync_rst_i asserted at N+1 edge: rvalid is 0 after reset and pointers are 0.
